karatsuba_iter_mult: RTL and testbench

Parametrised iterative Karatsuba multiplier. Forms the 2W-bit product of two W-bit operands using a single (W/2)×(W/2) multiplier, time-shared over three partial-product cycles plus one accumulate cycle. A start/busy/done handshake allows an upstream controller to issue back-to-back operations. It is the general-width successor to the fixed 32/16 iterative multiplier and sits beside the datapath adders and shifters as a shared arithmetic unit.

---
 rtl/karatsuba_iter_mult_if.sv | 15 +
 rtl/karatsuba_iter_mult.sv | 173 +++++++++++++++++
 tb/tb_karatsuba_iter_mult.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/karatsuba_iter_mult_if.sv
// Start/busy/done handshake and operand/result bus for karatsuba_iter_mult.
// The master side issues operations and the slave side is the multiplier.
interface karatsuba_iter_mult_if #(
   parameter int unsigned W = 32
);
   logic           start;
   logic [W-1:0]   a;
   logic [W-1:0]   b;
   logic           busy;
   logic           done;
   logic [2*W-1:0] product;

   modport master (output start, a, b, input busy, done, product);
   modport slave  (input start, a, b, output busy, done, product);
endinterface

// File: rtl/karatsuba_iter_mult.sv
// Iterative Karatsuba multiplier: one (W/2)x(W/2) multiplier shared over the
// HI, LO and MID cycles, followed by a single accumulate cycle.
// Optional feature: define KARATSUBA_SIGNED_EN for two's-complement operands.
module karatsuba_iter_mult #(
   parameter int unsigned W = 32
) (
   input logic                 clk,
   input logic                 rst,
   karatsuba_iter_mult_if.slave bus
);
   localparam int unsigned H = W / 2;

   typedef enum logic [2:0] {StIdle, StHi, StLo, StMid, StAcc} state_e;

   state_e         state_q, state_d;
   logic [W-1:0]   a_q, a_d, b_q, b_d;
   logic [W-1:0]   z2_q, z2_d, z0_q, z0_d;
   logic [W:0]     z1_q, z1_d;
   logic [2*W-1:0] product_q, product_d;
   logic           done_q, done_d;

   logic [H-1:0]   a_hi, a_lo, b_hi, b_lo, da, db, mul_x, mul_y;
   logic           a_lt, b_lt, sgn;
   logic [W-1:0]   mul_p;
   logic [W+1:0]   z_sum, z1_wide;
   logic           unused_z1_msb;
   logic [2*W-1:0] prod_mag, prod_res;
   logic [W-1:0]   a_in, b_in;

`ifdef KARATSUBA_SIGNED_EN
   logic neg_q, neg_d;
`endif

   assign a_hi = a_q[W-1:H];
   assign a_lo = a_q[H-1:0];
   assign b_hi = b_q[W-1:H];
   assign b_lo = b_q[H-1:0];

   // Absolute half differences and the sign of their product for the middle term
   always_comb begin
      a_lt = a_lo < a_hi;
      b_lt = b_lo < b_hi;
      da   = a_lt ? (a_hi - a_lo) : (a_lo - a_hi);
      db   = b_lt ? (b_hi - b_lo) : (b_lo - b_hi);
      sgn  = a_lt ^ b_lt;
   end

   // Shared multiplier operand select; zero outside the three multiply cycles
   always_comb begin
      mul_x = '0;
      mul_y = '0;
      unique case (state_q)
         StHi:    begin mul_x = a_hi; mul_y = b_hi; end
         StLo:    begin mul_x = a_lo; mul_y = b_lo; end
         StMid:   begin mul_x = da;   mul_y = db;   end
         default: ;
      endcase
   end

   assign mul_p = {{H{1'b0}}, mul_x} * {{H{1'b0}}, mul_y};

   // Middle term z1 = z2 + z0 -/+ m; two guard bits keep the subtraction exact
   always_comb begin
      z_sum         = {2'b00, z2_q} + {2'b00, z0_q};
      z1_wide       = sgn ? (z_sum + {2'b00, mul_p}) : (z_sum - {2'b00, mul_p});
      unused_z1_msb = z1_wide[W+1];
   end

   // Final recombination, with optional sign restore
   always_comb begin
      prod_mag = {z2_q, {W{1'b0}}}
               + ({{(W-1){1'b0}}, z1_q} << H)
               + {{W{1'b0}}, z0_q};
`ifdef KARATSUBA_SIGNED_EN
      prod_res = neg_q ? ({(2*W){1'b0}} - prod_mag) : prod_mag;
`else
      prod_res = prod_mag;
`endif
   end

   // Operand capture: magnitudes in signed builds, raw values otherwise
   always_comb begin
`ifdef KARATSUBA_SIGNED_EN
      a_in = bus.a[W-1] ? ({W{1'b0}} - bus.a) : bus.a;
      b_in = bus.b[W-1] ? ({W{1'b0}} - bus.b) : bus.b;
`else
      a_in = bus.a;
      b_in = bus.b;
`endif
   end

   // Next-state and datapath update decode
   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      z2_d      = z2_q;
      z0_d      = z0_q;
      z1_d      = z1_q;
      product_d = product_q;
      done_d    = 1'b0;
`ifdef KARATSUBA_SIGNED_EN
      neg_d     = neg_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (bus.start) begin
               state_d = StHi;
               a_d     = a_in;
               b_d     = b_in;
`ifdef KARATSUBA_SIGNED_EN
               neg_d   = bus.a[W-1] ^ bus.b[W-1];
`endif
            end
         end
         StHi: begin
            z2_d    = mul_p;
            state_d = StLo;
         end
         StLo: begin
            z0_d    = mul_p;
            state_d = StMid;
         end
         StMid: begin
            z1_d    = z1_wide[W:0];
            state_d = StAcc;
         end
         StAcc: begin
            product_d = prod_res;
            done_d    = 1'b1;
            state_d   = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= StIdle;
      else     state_q <= state_d;
   end

   // Datapath registers; reset also kills the result of any in-flight operation
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q       <= '0;
         b_q       <= '0;
         z2_q      <= '0;
         z0_q      <= '0;
         z1_q      <= '0;
         product_q <= '0;
         done_q    <= 1'b0;
`ifdef KARATSUBA_SIGNED_EN
         neg_q     <= 1'b0;
`endif
      end else begin
         a_q       <= a_d;
         b_q       <= b_d;
         z2_q      <= z2_d;
         z0_q      <= z0_d;
         z1_q      <= z1_d;
         product_q <= product_d;
         done_q    <= done_d;
`ifdef KARATSUBA_SIGNED_EN
         neg_q     <= neg_d;
`endif
      end
   end

   assign bus.busy    = (state_q != StIdle);
   assign bus.done    = done_q;
   assign bus.product = product_q;
endmodule

// File: tb/tb_karatsuba_iter_mult.sv
// Directed and random checks for karatsuba_iter_mult at W=32 and W=16.
module tb_karatsuba_iter_mult;
`ifdef KARATSUBA_SIGNED_EN
   localparam bit Sgn = 1'b1;
`else
   localparam bit Sgn = 1'b0;
`endif

   logic clk;
   logic rst;
   int   total;
   int   bad;

   karatsuba_iter_mult_if #(.W(32)) bus32 ();
   karatsuba_iter_mult_if #(.W(16)) bus16 ();

   karatsuba_iter_mult #(.W(32)) dut32 (.clk(clk), .rst(rst), .bus(bus32));
   karatsuba_iter_mult #(.W(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] exp_u;
      logic [63:0] exp_s;
   } vec_t;

   vec_t vecs[10];

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // One W=32 operation; checks busy, latency, pulse width and result hold
   task automatic op32(input string name, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] exp);
      int lat;
      @(negedge clk);
      bus32.start = 1'b1;
      bus32.a     = a;
      bus32.b     = b;
      @(posedge clk);
      @(negedge clk);
      bus32.start = 1'b0;
      bus32.a     = ~a;
      bus32.b     = ~b;
      check({name, "_busy"}, 64'(bus32.busy), 64'd1);
      lat = 0;
      while (bus32.done !== 1'b1 && lat < 10) begin
         @(negedge clk);
         lat++;
      end
      check({name, "_lat"}, 64'(lat), 64'd4);
      check({name, "_prod"}, bus32.product, exp);
      check({name, "_busy_at_done"}, 64'(bus32.busy), 64'd0);
      @(negedge clk);
      check({name, "_done_width"}, 64'(bus32.done), 64'd0);
      check({name, "_hold"}, bus32.product, exp);
   endtask

   initial begin
      int          n_done;
      int          idx[$];
      int          lat;
      logic [15:0] ra, rb;
      logic [31:0] exp16;

      total = 0;
      bad   = 0;
      rst   = 1'b1;
      bus32.start = 1'b0; bus32.a = '0; bus32.b = '0;
      bus16.start = 1'b0; bus16.a = '0; bus16.b = '0;

      vecs[0] = '{"all_ones",  32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001, 64'h1};
      vecs[1] = '{"mid_mixed", 32'h00010002, 32'h00030001, 64'h0000000300070002,
                  64'h0000000300070002};
      vecs[2] = '{"neg_one",   32'hFFFFFFFF, 32'h00000001, 64'h00000000FFFFFFFF,
                  64'hFFFFFFFFFFFFFFFF};
      vecs[3] = '{"zero",      32'h00000000, 32'h12345678, 64'h0, 64'h0};
      vecs[4] = '{"min_sq",    32'h80000000, 32'h80000000, 64'h4000000000000000,
                  64'h4000000000000000};
      vecs[5] = '{"min_x2",    32'h80000000, 32'h00000002, 64'h0000000100000000,
                  64'hFFFFFFFF00000000};
      vecs[6] = '{"low_sq",    32'h0000FFFF, 32'h0000FFFF, 64'h00000000FFFE0001,
                  64'h00000000FFFE0001};
      vecs[7] = '{"hi_x",      32'hFFFF0000, 32'h00010000, 64'h0000FFFF00000000,
                  64'hFFFFFFFF00000000};
      vecs[8] = '{"max_pos",   32'h7FFFFFFF, 32'h7FFFFFFF, 64'h3FFFFFFF00000001,
                  64'h3FFFFFFF00000001};
      vecs[9] = '{"both_lt",   32'h00020001, 32'h00020001, 64'h0000000400040001,
                  64'h0000000400040001};

      // Reset is asynchronous: outputs clear before any clock edge
      #1;
      check("rst_busy", 64'(bus32.busy), 64'd0);
      check("rst_done", 64'(bus32.done), 64'd0);
      check("rst_prod", bus32.product, 64'd0);
      #21 rst = 1'b0;

      for (int i = 0; i < 10; i++)
         op32(vecs[i].name, vecs[i].a, vecs[i].b, Sgn ? vecs[i].exp_s : vecs[i].exp_u);

      // start held high: accepts every 5 cycles; operand noise while busy is ignored
      @(negedge clk);
      bus32.start = 1'b1;
      bus32.a     = 32'h00010000;
      bus32.b     = 32'h00010000;
      for (int i = 1; i <= 12; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (bus32.done === 1'b1) begin
            idx.push_back(i);
            check("held_prod", bus32.product, 64'h0000000100000000);
         end
         bus32.a = bus32.busy ? 32'hDEAD0000 : 32'h00010000;
      end
      bus32.start = 1'b0;
      check("held_ndone", 64'(idx.size()), 64'd2);
      if (idx.size() == 2) begin
         check("held_first", 64'(idx[0]), 64'd5);
         check("held_gap", 64'(idx[1] - idx[0]), 64'd5);
      end
      repeat (6) @(negedge clk);

      // Reset mid-operation: immediate clear, no done for the aborted op
      @(negedge clk);
      bus32.start = 1'b1;
      bus32.a     = 32'hFFFFFFFF;
      bus32.b     = 32'hFFFFFFFF;
      @(posedge clk);
      @(negedge clk);
      bus32.start = 1'b0;
      @(posedge clk);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("abort_busy", 64'(bus32.busy), 64'd0);
      check("abort_done", 64'(bus32.done), 64'd0);
      check("abort_prod", bus32.product, 64'd0);
      #1 rst = 1'b0;
      n_done = 0;
      repeat (8) begin
         @(negedge clk);
         if (bus32.done === 1'b1) n_done++;
      end
      check("abort_no_done", 64'(n_done), 64'd0);
      check("abort_prod_after", bus32.product, 64'd0);
      op32("after_rst", 32'h00010002, 32'h00030001, 64'h0000000300070002);

      // W=16 random sweep against a behavioural product
      for (int n = 0; n < 10000; n++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         if (Sgn) exp16 = $signed({{16{ra[15]}}, ra}) * $signed({{16{rb[15]}}, rb});
         else     exp16 = {16'h0, ra} * {16'h0, rb};
         @(negedge clk);
         bus16.start = 1'b1;
         bus16.a     = ra;
         bus16.b     = rb;
         @(posedge clk);
         @(negedge clk);
         bus16.start = 1'b0;
         lat = 0;
         while (bus16.done !== 1'b1 && lat < 10) begin
            @(negedge clk);
            lat++;
         end
         if (lat != 4) check("w16_lat", 64'(lat), 64'd4);
         check("w16_prod", 64'(bus16.product), 64'(exp16));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
